// File: rtl/demux_distributor_1x4_if.sv
// Bundle of the 1-to-4 distributor's upstream, downstream and status signals.
// master = the environment driving the distributor; slave = the distributor itself.
interface demux_distributor_1x4_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [1:0]         in_sel;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         rr_ptr;
    logic [15:0]        xfer_cnt;

    modport master (
        output in_data,
        output in_valid,
        output mode,
        output in_sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  rr_ptr,
        input  xfer_cnt
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  in_sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output rr_ptr,
        output xfer_cnt
    );
endinterface

// File: rtl/demux_distributor_1x4.sv
// One-input, four-output distributor with a one-word register per channel.
// Target channel comes from a round-robin pointer (mode=0) or from in_sel (mode=1).
module demux_distributor_1x4 #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_distributor_1x4_if.slave  bus
);

    logic [1:0]  tgt;
    logic        xfer;
    logic [3:0]  valid_reg;
    logic [3:0]  load;
    logic [3:0]  drain;
    logic [1:0]  rr_ptr_reg;
    logic [1:0]  rr_ptr_next;
    logic [15:0] xfer_cnt_reg;
    logic [15:0] xfer_cnt_next;

    // Readiness looks only at the target slot, so a full channel with its
    // consumer active still takes a new word in the same cycle it drains.
    assign tgt          = bus.mode ? bus.in_sel : rr_ptr_reg;
    assign bus.in_ready = ~valid_reg[tgt] | bus.out_ready[tgt];
    assign xfer         = bus.in_valid & bus.in_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [WIDTH-1:0] data_reg;
            logic             vld_reg;

            assign load[gi]  = xfer & (tgt == 2'(gi));
            assign drain[gi] = vld_reg & bus.out_ready[gi];

            // Load wins over drain so a simultaneous replace keeps the slot full.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    vld_reg  <= 1'b0;
                end else if (load[gi]) begin
                    data_reg <= bus.in_data;
                    vld_reg  <= 1'b1;
                end else if (drain[gi]) begin
                    vld_reg  <= 1'b0;
                end
            end

            assign valid_reg[gi]                     = vld_reg;
            assign bus.out_data[gi*WIDTH +: WIDTH]   = data_reg;
        end
    endgenerate

    // The pointer only moves on an accepted round-robin word, so a stalled
    // channel is retried rather than skipped, and addressed traffic leaves it alone.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (xfer && !bus.mode) begin
            rr_ptr_next = rr_ptr_reg + 2'd1;
        end
    end

    always_comb begin
        xfer_cnt_next = xfer_cnt_reg;
        if (xfer) begin
            xfer_cnt_next = xfer_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= 2'd0;
            xfer_cnt_reg <= 16'd0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            xfer_cnt_reg <= xfer_cnt_next;
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.rr_ptr    = rr_ptr_reg;
    assign bus.xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_demux_distributor_1x4.sv
// Self-checking bench for demux_distributor_1x4: directed table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_demux_distributor_1x4;

    logic clk;
    logic rst_n;

    demux_distributor_1x4_if #(.WIDTH(8)) bus ();

    demux_distributor_1x4 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: four slots, a pointer and a counter, updated by the rules.
    bit          m_v   [4];
    logic [7:0]  m_d   [4];
    logic [1:0]  m_ptr;
    logic [15:0] m_cnt;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       md;
        logic [1:0] sel;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_vout;
        logic [1:0] exp_ptr;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_dout();
        return {m_d[3], m_d[2], m_d[1], m_d[0]};
    endfunction

    function automatic logic [3:0] m_vout();
        return {m_v[3], m_v[2], m_v[1], m_v[0]};
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".out_valid"}, {28'd0, bus.out_valid}, {28'd0, m_vout()});
        check({tag, ".out_data"},  bus.out_data, m_dout());
        check({tag, ".rr_ptr"},    {30'd0, bus.rr_ptr}, {30'd0, m_ptr});
        check({tag, ".xfer_cnt"},  {16'd0, bus.xfer_cnt}, {16'd0, m_cnt});
    endtask

    // Called 1ns after a rising edge; applies one cycle of stimulus.
    task automatic cycle(input logic vld, input logic [7:0] d, input logic md,
                         input logic [1:0] sel, input logic [3:0] ordy,
                         input bit chk, output logic rdy_seen);
        logic [1:0] t;
        bit         exp_rdy;
        bit         acc;
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.mode      = md;
        bus.in_sel    = sel;
        bus.out_ready = ordy;
        #1;
        rdy_seen = bus.in_ready;
        t        = md ? sel : m_ptr;
        exp_rdy  = !m_v[t] || ordy[t];
        acc      = vld && exp_rdy;
        if (chk) check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            if (acc && k == int'(t)) begin
                m_v[k] = 1'b1;
                m_d[k] = d;
            end else if (m_v[k] && ordy[k]) begin
                m_v[k] = 1'b0;
            end
        end
        if (acc) begin
            m_cnt = m_cnt + 16'd1;
            if (!md) m_ptr = m_ptr + 2'd1;
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check_state("cyc");
            $display("xfer t=%0t vld=%0b d=%02h mode=%0b sel=%0d ordy=%04b rdy=%0b acc=%0b -> vout=%04b ptr=%0d cnt=%0d",
                     $time, vld, d, md, sel, ordy, rdy_seen, acc, bus.out_valid, bus.rr_ptr, bus.xfer_cnt);
        end
    endtask

    // Asserts reset between edges and checks the asynchronous clear before any edge.
    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = 8'h00;
        end
        m_ptr = 2'd0;
        m_cnt = 16'd0;
        #2;
        check_state("rst");
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_state("rst_hold");
        rst_n = 1'b1;
    endtask

    logic r;

    initial begin
        tbl[0] = '{1'b1, 8'h50, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0001, 2'd1, 32'h0000_0050};
        tbl[1] = '{1'b1, 8'h51, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0011, 2'd2, 32'h0000_5150};
        tbl[2] = '{1'b1, 8'h52, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0111, 2'd3, 32'h0052_5150};
        tbl[3] = '{1'b1, 8'h53, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b1111, 2'd0, 32'h5352_5150};
        tbl[4] = '{1'b1, 8'h54, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b1111, 2'd0, 32'h5352_5150};
        tbl[5] = '{1'b1, 8'h54, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b1111, 2'd1, 32'h5352_5154};
        tbl[6] = '{1'b0, 8'hEE, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd1, 32'h5352_5154};
        tbl[7] = '{1'b1, 8'h11, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0100, 2'd1, 32'h5311_5154};
        tbl[8] = '{1'b1, 8'h22, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 2'd1, 32'h5311_5154};

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.mode      = 1'b0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;
        #6;
        do_reset();

        // Directed table: fill under backpressure, replace-on-drain, addressed stall.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].vld, tbl[i].data, tbl[i].md, tbl[i].sel, tbl[i].ordy, 1'b1, r);
            check($sformatf("tbl%0d.rdy", i),  {31'd0, r}, {31'd0, tbl[i].exp_rdy});
            check($sformatf("tbl%0d.vout", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].exp_vout});
            check($sformatf("tbl%0d.ptr", i),  {30'd0, bus.rr_ptr}, {30'd0, tbl[i].exp_ptr});
            check($sformatf("tbl%0d.dout", i), bus.out_data, tbl[i].exp_dout);
        end

        // Streaming round-robin at full rate.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'hA0 + 8'(i);
            cycle(1'b1, w, 1'b0, 2'd0, 4'b1111, 1'b1, r);
            check("rr.rdy", {31'd0, r}, 32'd1);
            check("rr.slot_valid", {31'd0, bus.out_valid[i % 4]}, 32'd1);
            check("rr.slot_data", {24'd0, bus.out_data[(i % 4) * 8 +: 8]}, {24'd0, w});
        end
        check("rr.xfer_cnt", {16'd0, bus.xfer_cnt}, 32'd8);
        check("rr.ptr", {30'd0, bus.rr_ptr}, 32'd0);

        // Pointer is frozen across an addressed burst and resumes afterwards.
        do_reset();
        cycle(1'b1, 8'h01, 1'b0, 2'd0, 4'b1111, 1'b1, r);
        cycle(1'b1, 8'h02, 1'b0, 2'd0, 4'b1111, 1'b1, r);
        check("mode.ptr_before", {30'd0, bus.rr_ptr}, 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b1, 2'd0, 4'b1111, 1'b1, r);
        check("mode.ptr_held", {30'd0, bus.rr_ptr}, 32'd2);
        cycle(1'b1, 8'h77, 1'b0, 2'd3, 4'b1111, 1'b1, r);
        check("mode.resume_valid", {31'd0, bus.out_valid[2]}, 32'd1);
        check("mode.resume_data", {24'd0, bus.out_data[23:16]}, 32'h77);
        check("mode.ptr_after", {30'd0, bus.rr_ptr}, 32'd3);

        // Mid-stream reset with out_valid=1011, rr_ptr=1.
        do_reset();
        cycle(1'b1, 8'h31, 1'b0, 2'd0, 4'b0000, 1'b1, r);
        cycle(1'b1, 8'h32, 1'b1, 2'd1, 4'b0000, 1'b1, r);
        cycle(1'b1, 8'h33, 1'b1, 2'd3, 4'b0000, 1'b1, r);
        check("arst.pre_valid", {28'd0, bus.out_valid}, 32'hB);
        check("arst.pre_ptr", {30'd0, bus.rr_ptr}, 32'd1);
        do_reset();
        cycle(1'b1, 8'h44, 1'b0, 2'd2, 4'b0000, 1'b1, r);
        check("arst.first_to_ch0", {28'd0, bus.out_valid}, 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       vld;
            logic       md;
            vld = ($urandom_range(0, 3) != 0);
            md  = ($urandom_range(0, 3) == 0);
            cycle(vld, 8'($urandom), md, 2'($urandom), 4'($urandom), 1'b1, r);
        end

        // Transfer counter wrap.
        do_reset();
        for (int i = 0; i < 65535; i++) cycle(1'b1, 8'(i), 1'b0, 2'd0, 4'b1111, 1'b0, r);
        check("cnt.max", {16'd0, bus.xfer_cnt}, 32'hFFFF);
        cycle(1'b1, 8'hFF, 1'b0, 2'd0, 4'b1111, 1'b1, r);
        check("cnt.wrap", {16'd0, bus.xfer_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
